// File: rtl/mfda_ctrl_pkg.sv
// Shared types and widths for the microfluidic assay controller blocks.
package mfda_ctrl_pkg;

  localparam int VOL_W    = 12;
  localparam int SETTLE_W = 8;
  localparam int DATA_W   = 8;
  localparam int CNT_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISPENSE,
    ST_SETTLE,
    ST_WAIT_DET,
    ST_RESPOND
  } state_t;

endpackage

// File: rtl/assay_dispenser_cycle_counter.sv
// Loadable down-counter with a zero flag; a load takes priority over a decrement,
// and the count saturates at zero.
module cycle_counter
  import mfda_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/assay_dispenser.sv
// Dispense / settle / detect sequencer: pumps cmd_volume*PULSE_CYCLES cycles,
// waits cmd_settle cycles, then returns one detector reading or a timeout.
module assay_dispenser
  import mfda_ctrl_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned DET_TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [VOL_W-1:0]    cmd_volume,
  input  logic [SETTLE_W-1:0] cmd_settle,
  output logic                pump_en,
  input  logic                det_valid,
  input  logic [DATA_W-1:0]   det_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_timeout,
  output logic                busy
);

  state_t              state_q, state_d;
  logic                pump_en_q, pump_en_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic                settle_nz_q, settle_nz_d;

  logic                disp_load, disp_dec, disp_zero;
  logic                settle_load, settle_dec, settle_zero;
  logic                tmo_load, tmo_dec, tmo_zero;
  logic [CNT_W-1:0]    disp_load_val, settle_load_val, tmo_load_val;

  // Counters hold N-1 so that a phase of N cycles ends on the cycle its count is zero.
  assign disp_load_val   = (CNT_W'(cmd_volume) * CNT_W'(PULSE_CYCLES)) - CNT_W'(1);
  assign settle_load_val = CNT_W'(cmd_settle) - CNT_W'(1);
  assign tmo_load_val    = CNT_W'(DET_TIMEOUT - 1);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the case statement can leave a value unassigned and infer a latch.
    state_d       = state_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    settle_nz_d   = settle_nz_q;
    disp_load     = 1'b0;
    disp_dec      = 1'b0;
    settle_load   = 1'b0;
    settle_dec    = 1'b0;
    tmo_dec       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          disp_load   = 1'b1;
          settle_load = 1'b1;
          settle_nz_d = (cmd_settle != '0);
          if (cmd_volume != '0)      state_d = ST_DISPENSE;
          else if (cmd_settle != '0) state_d = ST_SETTLE;
          else                       state_d = ST_WAIT_DET;
        end
      end
      ST_DISPENSE: begin
        disp_dec = 1'b1;
        if (disp_zero) state_d = settle_nz_q ? ST_SETTLE : ST_WAIT_DET;
      end
      ST_SETTLE: begin
        settle_dec = 1'b1;
        if (settle_zero) state_d = ST_WAIT_DET;
      end
      ST_WAIT_DET: begin
        tmo_dec = 1'b1;
        // A reading on the final timeout cycle still counts as a reading.
        if (det_valid) begin
          rsp_data_d    = det_data;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESPOND;
        end else if (tmo_zero) begin
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    tmo_load  = (state_d == ST_WAIT_DET) && (state_q != ST_WAIT_DET);
    pump_en_d = (state_d == ST_DISPENSE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pump_en_q     <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      settle_nz_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pump_en_q     <= pump_en_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      settle_nz_q   <= settle_nz_d;
    end
  end

  cycle_counter u_disp_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (disp_load),
    .load_val (disp_load_val),
    .dec      (disp_dec),
    .zero     (disp_zero)
  );

  cycle_counter u_settle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (settle_load),
    .load_val (settle_load_val),
    .dec      (settle_dec),
    .zero     (settle_zero)
  );

  cycle_counter u_tmo_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (tmo_load),
    .load_val (tmo_load_val),
    .dec      (tmo_dec),
    .zero     (tmo_zero)
  );

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESPOND);
  assign pump_en     = pump_en_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_assay_dispenser.sv
// Directed bench for assay_dispenser: a table of command/detector vectors with
// hand-computed latency and response, plus stall and mid-dispense reset sequences.
module tb_assay_dispenser;
  import mfda_ctrl_pkg::*;

  localparam int PC  = 4;
  localparam int TMO = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [VOL_W-1:0]    cmd_volume;
  logic [SETTLE_W-1:0] cmd_settle;
  logic                pump_en;
  logic                det_valid;
  logic [DATA_W-1:0]   det_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_timeout;
  logic                busy;

  assay_dispenser #(.PULSE_CYCLES(PC), .DET_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_volume  (cmd_volume),
    .cmd_settle  (cmd_settle),
    .pump_en     (pump_en),
    .det_valid   (det_valid),
    .det_data    (det_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // det_cyc: which WAIT_DET cycle (1-based) carries the reading, 0 = none.
  // stray_cyc: cycle after acceptance carrying a reading outside WAIT_DET, 0 = none.
  // exp_lat: cycles after the accepting edge until rsp_valid is first seen.
  typedef struct {
    int         vol;
    int         settle;
    int         det_cyc;
    logic [7:0] det_byte;
    int         stray_cyc;
    int         exp_pump;
    int         exp_lat;
    logic [7:0] exp_data;
    logic       exp_tmo;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int det_at;
    int pump_cnt;
    int pump_last;
    int lat;
    int c;
    det_at = (v.det_cyc > 0) ? (v.vol * PC + v.settle + v.det_cyc) : v.stray_cyc;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_volume = v.vol[VOL_W-1:0];
    cmd_settle = v.settle[SETTLE_W-1:0];
    check($sformatf("v%0d_cmd_ready_idle", idx), cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    c = 1; lat = 0; pump_cnt = 0; pump_last = 0;
    while (lat == 0 && c <= v.exp_lat + 50) begin
      if (rsp_valid) begin
        lat = c;
      end else begin
        if (pump_en) begin
          pump_cnt++;
          pump_last = c;
        end
        det_valid = (c == det_at);
        det_data  = det_valid ? v.det_byte : 8'hAA;
        @(negedge clk);
        c++;
      end
    end
    det_valid = 1'b0;
    check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d_pump_cycles", idx), pump_cnt, v.exp_pump);
    check($sformatf("v%0d_pump_last", idx), pump_last, v.exp_pump);
    check($sformatf("v%0d_rsp_data", idx), rsp_data, v.exp_data);
    check($sformatf("v%0d_rsp_timeout", idx), rsp_timeout, v.exp_tmo);
    check($sformatf("v%0d_cmd_ready_resp", idx), cmd_ready, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check($sformatf("v%0d_idle_after_hs", idx), {busy, rsp_valid, cmd_ready}, 3'b001);
  endtask

  vec_t vecs[9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rsp_seen;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_volume = '0;
    cmd_settle = '0;
    det_valid  = 1'b0;
    det_data   = '0;
    rsp_ready  = 1'b0;

    vecs[0] = '{3, 2, 2, 8'h5A, 0, 12, 17, 8'h5A, 1'b0};
    vecs[1] = '{0, 0, 1, 8'h33, 0, 0, 2, 8'h33, 1'b0};
    vecs[2] = '{0, 0, 0, 8'h00, 0, 0, 17, 8'h00, 1'b1};
    vecs[3] = '{1, 0, 16, 8'hC3, 0, 4, 21, 8'hC3, 1'b0};
    vecs[4] = '{2, 5, 4, 8'h01, 0, 8, 18, 8'h01, 1'b0};
    vecs[5] = '{0, 3, 1, 8'hFF, 0, 0, 5, 8'hFF, 1'b0};
    vecs[6] = '{2, 1, 0, 8'hE7, 3, 8, 26, 8'h00, 1'b1};
    vecs[7] = '{0, 4, 0, 8'h99, 2, 0, 21, 8'h00, 1'b1};
    vecs[8] = '{4095, 0, 1, 8'h3C, 0, 16380, 16382, 8'h3C, 1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_ready_busy_valid", {cmd_ready, busy, rsp_valid}, 3'b100);
    check("reset_pump_en", pump_en, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_timeout", rsp_timeout, 0);

    // A reading while idle must be ignored.
    det_valid = 1'b1;
    det_data  = 8'h77;
    @(negedge clk);
    det_valid = 1'b0;
    check("idle_det_ignored", {busy, rsp_data}, 9'h000);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Response stall with cmd_valid held high throughout.
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_volume = 12'd1;
    cmd_settle = 8'd0;
    @(negedge clk);
    cmd_volume = 12'd0;
    for (int c = 1; c <= 5; c++) begin
      det_valid = (c == 5);
      det_data  = (c == 5) ? 8'hA5 : 8'h11;
      @(negedge clk);
    end
    det_valid = 1'b0;
    for (int c = 6; c <= 11; c++) begin
      check($sformatf("stall_c%0d_valid_ready", c), {rsp_valid, cmd_ready}, 2'b10);
      check($sformatf("stall_c%0d_data", c), {rsp_timeout, rsp_data}, 9'h0A5);
      if (c == 11) rsp_ready = 1'b1;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    check("stall_ready_after_hs", cmd_ready, 1);
    @(negedge clk);
    check("stall_next_accepted", {busy, cmd_ready}, 2'b10);
    cmd_valid = 1'b0;
    det_valid = 1'b1;
    det_data  = 8'h6E;
    @(negedge clk);
    det_valid = 1'b0;
    check("stall_next_rsp", {rsp_valid, rsp_timeout, rsp_data}, 10'h26E);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset on the 6th DISPENSE cycle discards the command.
    cmd_valid  = 1'b1;
    cmd_volume = 12'd3;
    cmd_settle = 8'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) begin
        check("rst_pump_before", pump_en, 1);
        rst = 1'b1;
      end
      @(negedge clk);
    end
    rst = 1'b0;
    check("rst_pump_dropped", pump_en, 0);
    check("rst_ready_busy_valid", {cmd_ready, busy, rsp_valid}, 3'b100);
    check("rst_rsp_cleared", {rsp_timeout, rsp_data}, 9'h000);
    rsp_seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (rsp_valid || pump_en) rsp_seen++;
      @(negedge clk);
    end
    check("rst_no_response", rsp_seen, 0);

    run_vec('{0, 0, 1, 8'h42, 0, 0, 2, 8'h42, 1'b0}, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/assay_dispenser.md
ASSAY_DISPENSER -- requirements
Module: assay_dispenser

Interface
REQ-001 The block SHALL provide parameter PULSE_CYCLES, default 4, giving the clock cycles of pump_en per volume unit (range 1..15).
REQ-002 The block SHALL provide parameter DET_TIMEOUT, default 1024, giving the maximum cycles spent waiting for a detector result (range 1..65535).
REQ-003 clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  the host offers a dispense command.
REQ-006 cmd_ready  output  1  the block can accept a command.
REQ-007 cmd_volume  input  12  volume units to dispense.
REQ-008 cmd_settle  input  8  settle cycles after dispensing.
REQ-009 pump_en  output  1  drives the Source inlet valve/pump, registered.
REQ-010 det_valid  input  1  single-cycle strobe from the detector on the Out port.
REQ-011 det_data  input  8  detector reading, qualified by det_valid.
REQ-012 rsp_valid  output  1  a result is available.
REQ-013 rsp_ready  input  1  the host accepts the result.
REQ-014 rsp_data  output  8  the captured detector reading.
REQ-015 rsp_timeout  output  1  the result was produced by timeout, not by a reading.
REQ-016 busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 The state machine SHALL have exactly five states: IDLE, DISPENSE, SETTLE, WAIT_DET and RESPOND.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a cycle where cmd_valid and cmd_ready are both 1, and cmd_volume and cmd_settle are latched on that cycle.
REQ-019 On acceptance, the block SHALL go to DISPENSE if cmd_volume>0, else to SETTLE if cmd_settle>0, else to WAIT_DET.
REQ-020 pump_en SHALL rise on the first cycle after acceptance and stay high for exactly cmd_volume*PULSE_CYCLES consecutive cycles; it SHALL be low in every other state.
REQ-021 The dispense counter SHALL be at least 16 bits wide so that 4095*15 does not overflow.
REQ-022 SETTLE SHALL last exactly the latched cmd_settle cycles, then move to WAIT_DET.
REQ-023 det_valid outside WAIT_DET SHALL be ignored and SHALL NOT be captured or counted.
REQ-024 In WAIT_DET, det_valid=1 SHALL capture det_data into rsp_data, clear rsp_timeout and move to RESPOND on the next cycle.
REQ-025 If DET_TIMEOUT cycles pass in WAIT_DET without det_valid, the block SHALL set rsp_data=0 and rsp_timeout=1, then move to RESPOND.
REQ-026 If det_valid arrives on the same cycle the timeout expires, the reading SHALL win and rsp_timeout SHALL be 0.
REQ-027 rsp_valid SHALL be 1 exactly while in RESPOND; rsp_data and rsp_timeout SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-028 When rsp_valid and rsp_ready are both 1, the block SHALL return to IDLE next cycle, with cmd_ready=1 on that cycle.
REQ-029 Command-to-response latency with no stall SHALL be 1 + volume*PULSE_CYCLES + settle + detector wait cycles.

Reset
REQ-030 While rst=1, on the next clock edge: state=IDLE, pump_en=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, busy=0, cmd_ready=1, and all counters=0.
REQ-031 Reset in any state, including mid-DISPENSE, SHALL drop pump_en on the next edge and discard the in-flight command with no response.

Structure
REQ-032 The state enum and the width constants (VOL_W=12, SETTLE_W=8, DATA_W=8, CNT_W=16) SHALL live in the shared package mfda_ctrl_pkg.
REQ-033 One sub-module, cycle_counter, SHALL be used: a loadable CNT_W down-counter with a zero flag, instanced for the dispense, settle and timeout counts.

Verification
REQ-034 Scenario: volume=3, settle=2, PULSE_CYCLES=4, det_valid with data 0x5A two cycles into WAIT_DET -> pump_en high for exactly 12 cycles, rsp_valid with rsp_data=0x5A, rsp_timeout=0.
REQ-035 Scenario: volume=0, settle=0 -> no pump_en pulse, WAIT_DET is entered the cycle after acceptance.
REQ-036 Scenario: no det_valid with DET_TIMEOUT=16 -> rsp_valid after 16 WAIT_DET cycles with rsp_data=0, rsp_timeout=1.
REQ-037 Scenario: det_valid during DISPENSE, then a timeout -> the stray reading is ignored and rsp_timeout=1.
REQ-038 Scenario: rsp_ready held 0 for 5 cycles, and cmd_valid=1 throughout -> rsp_data stable, cmd_ready=0, and the next command is accepted only after the handshake.
REQ-039 Scenario: rst asserted on the 6th cycle of DISPENSE -> pump_en=0 and cmd_ready=1 next cycle, and no response is produced.
